// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the five-stage MIPS core.
// Detects load-use hazards against the held instruction, stalls IF/ID and inserts bubbles.
module id_ex_reg #(
    parameter int unsigned MEMREAD_BIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_pc_4,
    input  logic [31:0] id_ir,
    input  logic [31:0] id_signal,
    input  logic [31:0] id_r1,
    input  logic [31:0] id_r2,
    input  logic [31:0] id_ext,
    input  logic [31:0] id_v0,
    input  logic [31:0] id_a0,
    input  logic [4:0]  id_dst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_jb,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_pc_4,
    output logic [31:0] ex_ir,
    output logic [31:0] ex_signal,
    output logic [31:0] ex_r1,
    output logic [31:0] ex_r2,
    output logic [31:0] ex_ext,
    output logic [31:0] ex_v0,
    output logic [31:0] ex_a0,
    output logic [4:0]  ex_dst,
    output logic        lu,
    output logic        stall,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] ir;
        logic [31:0] signal;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] ext;
        logic [31:0] v0;
        logic [31:0] a0;
        logic [4:0]  dst;
    } bundle_t;

    bundle_t     bundle_d, bundle_q, id_bundle;
    logic        lu_d, lu_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] flush_cnt_d, flush_cnt_q;
    logic        hz;
    logic        rs_match, rt_match;

    always_comb begin
        id_bundle.pc     = id_pc;
        id_bundle.pc_4   = id_pc_4;
        id_bundle.ir     = id_ir;
        id_bundle.signal = id_signal;
        id_bundle.r1     = id_r1;
        id_bundle.r2     = id_r2;
        id_bundle.ext    = id_ext;
        id_bundle.v0     = id_v0;
        id_bundle.a0     = id_a0;
        id_bundle.dst    = id_dst;
    end

    // A bubble has signal = 0 and dst = 0, so it can never raise a hazard itself.
    always_comb begin
        rs_match = id_use_rs && (id_rs == bundle_q.dst);
        rt_match = id_use_rt && (id_rt == bundle_q.dst);
        hz       = bundle_q.signal[MEMREAD_BIT] && (bundle_q.dst != 5'd0) && (rs_match || rt_match);
        stall    = en && hz && !ex_jb;
    end

    always_comb begin
        bundle_d    = bundle_q;
        lu_d        = lu_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (en) begin
            if (ex_jb) begin
                // ID holds a wrong-path instruction, so any hazard it shows is moot.
                bundle_d    = '0;
                lu_d        = 1'b0;
                flush_cnt_d = flush_cnt_q + 32'd1;
            end else if (hz) begin
                bundle_d    = '0;
                lu_d        = 1'b1;
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else begin
                bundle_d    = id_bundle;
                lu_d        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            lu_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            bundle_q    <= bundle_d;
            lu_q        <= lu_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_pc     = bundle_q.pc;
    assign ex_pc_4   = bundle_q.pc_4;
    assign ex_ir     = bundle_q.ir;
    assign ex_signal = bundle_q.signal;
    assign ex_r1     = bundle_q.r1;
    assign ex_r2     = bundle_q.r2;
    assign ex_ext    = bundle_q.ext;
    assign ex_v0     = bundle_q.v0;
    assign ex_a0     = bundle_q.a0;
    assign ex_dst    = bundle_q.dst;
    assign lu        = lu_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: passthrough, load-use stall, flush priority, hold, wrap, async reset.
module tb_id_ex_reg;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] id_pc, id_pc_4, id_ir, id_signal, id_r1, id_r2, id_ext, id_v0, id_a0;
    logic [4:0]  id_dst, id_rs, id_rt;
    logic        id_use_rs, id_use_rt, ex_jb;
    logic [31:0] ex_pc, ex_pc_4, ex_ir, ex_signal, ex_r1, ex_r2, ex_ext, ex_v0, ex_a0;
    logic [4:0]  ex_dst;
    logic        lu, stall;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int passes = 0;

    id_ex_reg #(.MEMREAD_BIT(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .id_pc(id_pc), .id_pc_4(id_pc_4), .id_ir(id_ir), .id_signal(id_signal),
        .id_r1(id_r1), .id_r2(id_r2), .id_ext(id_ext), .id_v0(id_v0), .id_a0(id_a0),
        .id_dst(id_dst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_jb(ex_jb),
        .ex_pc(ex_pc), .ex_pc_4(ex_pc_4), .ex_ir(ex_ir), .ex_signal(ex_signal),
        .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_ext(ex_ext), .ex_v0(ex_v0), .ex_a0(ex_a0),
        .ex_dst(ex_dst), .lu(lu), .stall(stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] sig,
                          input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt);
        id_pc     = pc;
        id_pc_4   = pc + 32'd4;
        id_ir     = ir;
        id_signal = sig;
        id_r1     = 32'h1000_0000 | pc;
        id_r2     = 32'h2000_0000 | pc;
        id_ext    = {16'h0, ir[15:0]};
        id_v0     = 32'h0000_000A;
        id_a0     = 32'h0000_000B;
        id_dst    = dst;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        ex_jb = 1'b0;
        set_id(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #12;
        chk("reset_ex_ir", ex_ir, 32'h0);
        chk("reset_lu", {31'h0, lu}, 32'h0);
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_stall_cnt", stall_cnt, 32'h0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Passthrough: add $8,$9,$10
        set_id(32'h0040_0010, 32'h012A_4020, 32'h1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1);
        #1;
        chk("pass_stall_pre", {31'h0, stall}, 32'h0);
        step();
        chk("pass_ex_ir", ex_ir, 32'h012A_4020);
        chk("pass_ex_pc", ex_pc, 32'h0040_0010);
        chk("pass_ex_pc_4", ex_pc_4, 32'h0040_0014);
        chk("pass_ex_dst", {27'h0, ex_dst}, 32'd8);
        chk("pass_ex_r1", ex_r1, 32'h1040_0010);
        chk("pass_ex_signal", ex_signal, 32'h1);
        chk("pass_lu", {31'h0, lu}, 32'h0);
        chk("pass_stall", {31'h0, stall}, 32'h0);

        // lw $8,0($9) behind an ALU op writing $8: no load, no stall
        set_id(32'h0040_0014, 32'h8D28_0000, 32'h8, 5'd8, 5'd9, 5'd8, 1'b1, 1'b0);
        #1;
        chk("alu_no_stall", {31'h0, stall}, 32'h0);
        step();

        // Consumer add $10,$8,$9 behind the load
        set_id(32'h0040_0018, 32'h0109_5020, 32'h1, 5'd10, 5'd8, 5'd9, 1'b1, 1'b1);
        #1;
        chk("lu_stall", {31'h0, stall}, 32'h1);
        step();
        chk("lu_bubble_ir", ex_ir, 32'h0);
        chk("lu_bubble_sig", ex_signal, 32'h0);
        chk("lu_bubble_dst", {27'h0, ex_dst}, 32'h0);
        chk("lu_bubble_lu", {31'h0, lu}, 32'h1);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_stall_clear", {31'h0, stall}, 32'h0);
        step();
        chk("lu_resume_ir", ex_ir, 32'h0109_5020);
        chk("lu_resume_pc", ex_pc, 32'h0040_0018);
        chk("lu_resume_lu", {31'h0, lu}, 32'h0);

        // Load to $0 never stalls
        set_id(32'h0040_001C, 32'h8C20_0000, 32'h8, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0);
        step();
        set_id(32'h0040_0020, 32'h0000_1820, 32'h1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        #1;
        chk("zero_no_stall", {31'h0, stall}, 32'h0);

        // Load $8, then consumer that names rt=8 without reading it
        set_id(32'h0040_0024, 32'h8C28_0000, 32'h8, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0);
        step();
        set_id(32'h0040_0028, 32'h00A8_1820, 32'h1, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0);
        #1;
        chk("rt_unused_no_stall", {31'h0, stall}, 32'h0);
        id_use_rt = 1'b1;
        #1;
        chk("rt_used_stall", {31'h0, stall}, 32'h1);

        // Flush beats stall
        ex_jb = 1'b1;
        #1;
        chk("flush_stall", {31'h0, stall}, 32'h0);
        step();
        ex_jb = 1'b0;
        chk("flush_bubble_ir", ex_ir, 32'h0);
        chk("flush_lu", {31'h0, lu}, 32'h0);
        chk("flush_cnt", flush_cnt, 32'd1);
        chk("flush_stall_cnt", stall_cnt, 32'd1);

        // Capture a load, then freeze with a pending hazard
        set_id(32'h0040_002C, 32'h8D28_0004, 32'h8, 5'd8, 5'd9, 5'd8, 1'b1, 1'b0);
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_id(32'h0050_0000 + 32'(i * 4), 32'h0108_5020 + 32'(i), 32'h1, 5'd10,
                   5'd8, 5'd8, 1'b1, 1'b1);
            #1;
            chk("hold_stall", {31'h0, stall}, 32'h0);
            step();
        end
        chk("hold_ex_ir", ex_ir, 32'h8D28_0004);
        chk("hold_ex_pc", ex_pc, 32'h0040_002C);
        chk("hold_stall_cnt", stall_cnt, 32'd1);
        chk("hold_flush_cnt", flush_cnt, 32'd1);
        en = 1'b1;
        #1;
        chk("unhold_stall", {31'h0, stall}, 32'h1);
        step();
        chk("unhold_stall_cnt", stall_cnt, 32'd2);
        chk("unhold_lu", {31'h0, lu}, 32'h1);

        // Counter wrap
        set_id(32'h0040_0030, 32'h8D28_0008, 32'h8, 5'd8, 5'd9, 5'd8, 1'b1, 1'b0);
        step();
        set_id(32'h0040_0034, 32'h0109_5020, 32'h1, 5'd10, 5'd8, 5'd9, 1'b1, 1'b1);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
        step();
        chk("wrap_stall_cnt", stall_cnt, 32'h0);
        chk("wrap_lu", {31'h0, lu}, 32'h1);

        // Asynchronous reset in the middle of a stall
        set_id(32'h0040_0038, 32'h8D28_000C, 32'h8, 5'd8, 5'd9, 5'd8, 1'b1, 1'b0);
        step();
        set_id(32'h0040_003C, 32'h0109_5020, 32'h1, 5'd10, 5'd8, 5'd9, 1'b1, 1'b1);
        #1;
        chk("areset_pre_stall", {31'h0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("areset_ex_ir", ex_ir, 32'h0);
        chk("areset_ex_dst", {27'h0, ex_dst}, 32'h0);
        chk("areset_stall", {31'h0, stall}, 32'h0);
        chk("areset_flush_cnt", flush_cnt, 32'h0);
        #1;
        rst_n = 1'b1;
        set_id(32'h0040_0010, 32'h012A_4020, 32'h1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1);
        step();
        chk("post_reset_ir", ex_ir, 32'h012A_4020);
        chk("post_reset_lu", {31'h0, lu}, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the decode (ID) stage and the execute (EX) stage of the five-stage MIPS core. It captures the decoded instruction bundle every cycle. It also detects load-use hazards against the instruction it currently holds, requests an IF/ID stall, and inserts a bubble. When EX reports a taken jump or branch (`JB`), it flushes the wrong-path instruction. Its outputs drive the EX stage directly; `lu` feeds EX's `lu` input. Event counters support CPI statistics.

## Interface
- `MEMREAD_BIT`, default 3: bit of the control-signal word that marks a load.
- `clk` in 1: clock; rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: global run enable; 0 freezes all state.
- `id_pc`, `id_pc_4`, `id_ir`, `id_signal`, `id_r1`, `id_r2`, `id_ext`, `id_v0`, `id_a0` in 32 each: decoded bundle.
- `id_dst` in 5: destination register.
- `id_rs`, `id_rt` in 5: source register numbers of the ID instruction.
- `id_use_rs`, `id_use_rt` in 1: the ID instruction reads `rs`/`rt`.
- `ex_jb` in 1: EX `JB`; taken jump, branch or JR this cycle.
- `ex_pc`, `ex_pc_4`, `ex_ir`, `ex_signal`, `ex_r1`, `ex_r2`, `ex_ext`, `ex_v0`, `ex_a0` out 32 each: registered bundle.
- `ex_dst` out 5: registered destination.
- `lu` out 1: registered; 1 when the EX-side bundle is a load-use bubble.
- `stall` out 1: combinational; hold PC and IF/ID this cycle.
- `stall_cnt`, `flush_cnt` out 32: event counters.

## Operation
- Hazard term: `hz = ex_signal[MEMREAD_BIT] & (ex_dst != 0) & ((id_use_rs & id_rs == ex_dst) | (id_use_rt & id_rt == ex_dst))`.
- `stall = en & hz & ~ex_jb`.
- Per-edge action, in priority order:
  1. **Reset** (`rst_n = 0`): all registers and counters go to 0.
  2. **Hold** (`en = 0`): every register and counter keeps its value.
  3. **Flush** (`ex_jb = 1`): load a bubble with `lu <= 0`; `flush_cnt` increments. A hazard in the same cycle is ignored, because the ID instruction is wrong-path.
  4. **Stall** (`hz = 1`): load a bubble with `lu <= 1`; `stall_cnt` increments.
  5. **Normal**: capture all `id_*` inputs into the matching `ex_*` outputs; `lu <= 0`.
- Bubble: every `ex_*` field is 0. `ex_ir = 0` is the MIPS `sll $0,$0,0` NOP, and `ex_signal = 0` asserts no writes, branches or memory operations.
- A bubble never creates a hazard, because its `ex_signal` and `ex_dst` are 0.
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.
- Register 0 never creates a hazard.
- Only loads create stalls. ALU results reach the consumer through forwarding, which is outside this block.

## Timing
- Latency: 1 cycle from `id_*` to `ex_*`.
- `stall` is valid in the same cycle as the `id_*` inputs and registered `ex_*` state. It has no registered delay.
- A load-use pair produces exactly one stall cycle:
  - cycle N: `stall = 1`, IF/ID holds.
  - cycle N+1: EX holds the bubble with `lu = 1`; `hz` is now 0, so the held ID instruction is captured at the end of N+1.
- `lu` is high for exactly the cycles in which a stall bubble occupies EX.
- Reset value of every output is 0, `stall` included, since `hz` is 0 after reset.
- Reset is asynchronous: outputs clear immediately on `rst_n` falling, even mid-stall. Deassertion is assumed synchronous to `clk` upstream.
- While `en = 0`, `stall` is 0, but the frozen `ex_*` values still feed EX.

## Test plan
- **Reset:** drive `rst_n = 0` mid-run with non-zero outputs → all outputs and counters read 0 without waiting for a `clk` edge. After release, the first edge captures `id_*` with `en = 1`.
- **Passthrough:** `id_ir = 0x012A4020`, `id_pc = 0x00400010`, `id_dst = 8` → the next edge shows the same values on `ex_*`; `lu = 0`, `stall = 0`.
- **Load-use:**
  - EX holds a `lw` with `ex_dst = 8`; ID has `id_rs = 8`, `id_use_rs = 1` → `stall = 1` in that cycle.
  - Next cycle: `ex_ir = 0`, `lu = 1`, `stall_cnt = 1`.
  - The cycle after: the ID instruction appears in EX with `lu = 0`.
- **No false hazard:**
  - Load with `ex_dst = 0` and ID `rs = 0` → `stall = 0`.
  - Load with `ex_dst = 8`, ID `rt = 8`, `id_use_rt = 0` → `stall = 0`.
- **Flush beats stall:** `ex_jb = 1` together with a load-use condition → `stall = 0`; next cycle holds a bubble with `lu = 0`; `flush_cnt` increments and `stall_cnt` does not.
- **Hold and wrap:**
  - `en = 0` for 3 cycles while `id_*` inputs change → `ex_*` outputs and counters stay unchanged.
  - Preload `stall_cnt = 0xFFFFFFFF` (force), then trigger one stall → `stall_cnt = 0`.
